spi_tx_scheduler: RTL and testbench

Upstream feeder for the SPI master. Buffers 12-bit words from a producer through a valid/ready FIFO and launches them one at a time on the master's newd/din request. It detects acceptance and completion of each word by watching the master's cs. It enforces a minimum inter-word gap and flags masters that never accept a request.

---
 rtl/spi_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_spi_tx_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_tx_scheduler
// Brief    : Word FIFO feeding an SPI master over newd/din, tracking each
//            transfer through the master's chip select.
// Revision : 1.0
// ============================================================================
module spi_tx_scheduler #(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic                     cs_in,
    output logic                     newd,
    output logic [WIDTH-1:0]         din,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              tx_count,
    output logic                     timeout_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_AW:0]   c_FULL     = (c_AW+1)'(DEPTH);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_cs_q;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0]    r_wptr;
    logic [c_AW-1:0]    r_rptr;
    logic [c_AW:0]      r_count;
    logic [c_TW-1:0]    r_tmo;
    logic [c_GW-1:0]    r_gap;
    logic               r_launched;

    logic               w_push;
    logic               w_pop;
    logic               w_tmo_hit;

    assign in_ready   = (r_count != c_FULL) && !flush;
    assign w_push     = in_valid && in_ready;
    assign w_tmo_hit  = (r_tmo == c_TMO_LAST);
    // The launched word leaves the FIFO only once the master takes it or it
    // is abandoned; a flush in between already removed it, so no pop then.
    assign w_pop      = (r_state == S_REQ) && (!r_cs_q || w_tmo_hit)
                        && r_launched && !flush;
    assign fifo_count = r_count;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cs_q      <= 1'b1;
            r_tmo       <= '0;
            r_gap       <= '0;
            r_launched  <= 1'b0;
            newd        <= 1'b0;
            din         <= '0;
            tx_count    <= '0;
            timeout_err <= 1'b0;
        end else begin
            r_cs_q <= cs_in;
            if (flush)   r_launched  <= 1'b0;
            if (err_clr) timeout_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && !flush) begin
                        din        <= r_mem[r_rptr];
                        newd       <= 1'b1;
                        r_tmo      <= '0;
                        r_launched <= 1'b1;
                        r_state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!r_cs_q) begin
                        newd       <= 1'b0;
                        r_launched <= 1'b0;
                        r_state    <= S_ACTIVE;
                    end else if (w_tmo_hit) begin
                        newd        <= 1'b0;
                        r_launched  <= 1'b0;
                        timeout_err <= 1'b1;
                        r_gap       <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (r_cs_q) begin
                        tx_count <= tx_count + 16'd1;
                        r_gap    <= '0;
                        r_state  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_tx_scheduler
// Brief    : Directed bench for spi_tx_scheduler with a behavioural master.
// Revision : 1.0
// ============================================================================
module tb_spi_tx_scheduler;

    localparam int WIDTH      = 12;
    localparam int DEPTH      = 8;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             flush;
    logic             err_clr;
    logic             cs_in;
    logic             newd;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic [3:0]       fifo_count;
    logic [15:0]      tx_count;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = -1000;
    int accepted = 0;
    logic master_en = 1'b0;
    logic abort = 1'b0;
    logic prev_newd = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    spi_tx_scheduler #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .err_clr(err_clr), .cs_in(cs_in),
        .newd(newd), .din(din), .busy(busy), .fifo_count(fifo_count),
        .tx_count(tx_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records accepted words in the scoreboard, then advances one clock.
    task automatic step();
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            accepted++;
        end
        tick();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((busy || fifo_count != 0 || !cs_in) && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_cs_low(input int budget, input string tag);
        int n = 0;
        while (cs_in && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    // Behavioural master: takes newd, holds cs low for a word time, releases.
    initial begin
        logic [WIDTH-1:0] cap;
        cs_in = 1'b1;
        forever begin
            tick();
            if (newd && !prev_newd)
                check("newd_gap", 32'((cyc - last_rise) >= GAP_CYCLES), 32'd1);
            prev_newd = newd;
            if (master_en && newd && rst_n) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("din_order", 32'(din), 32'(exp_q.pop_front()));
                cap = din;
                cs_in = 1'b0;
                repeat (3) tick();
                if (!abort) check("newd_active", 32'(newd), 32'd0);
                repeat (11) tick();
                if (!abort) check("din_hold", 32'(din), 32'(cap));
                cs_in = 1'b1;
                last_rise = cyc;
                abort = 1'b0;
                prev_newd = newd;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic saw;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_newd",   32'(newd), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_count",  32'(fifo_count), 32'd0);
        check("rst_ready",  32'(in_ready), 32'd1);
        check("rst_din",    32'(din), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single word and launch latency
        master_en = 1'b1;
        in_valid = 1'b1; in_data = 12'hA5C;
        step();
        in_valid = 1'b0;
        check("lat_newd_lo", 32'(newd), 32'd0);
        check("lat_count",   32'(fifo_count), 32'd1);
        step();
        check("lat_newd_hi", 32'(newd), 32'd1);
        check("lat_din",     32'(din), 32'hA5C);
        check("lat_busy",    32'(busy), 32'd1);
        wait_idle(100, "single_done");
        check("single_tx", 32'(tx_count), 32'd1);

        // Burst of 10 into an 8-deep FIFO with the master stalled
        master_en = 1'b0;
        accepted = 0;
        saw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(i);
            if (fifo_count == 4'd8) begin
                check("full_ready", 32'(in_ready), 32'd0);
                saw = 1'b1;
            end
            step();
        end
        check("burst_full_seen", 32'(saw), 32'd1);
        check("burst_accepted", 32'(accepted), 32'd8);

        // Full FIFO with in_valid held across a pop
        in_data = 12'h0AB;
        master_en = 1'b1;
        n = 0;
        while (fifo_count == 4'd8 && n < 20) begin
            step();
            n++;
        end
        check("pop_count7", 32'(fifo_count), 32'd7);
        check("pop_no_push", 32'(accepted), 32'd8);
        step();
        check("push_after_pop", 32'(fifo_count), 32'd8);
        check("push_accepted", 32'(accepted), 32'd9);
        in_valid = 1'b0;
        wait_idle(1500, "burst_done");
        check("burst_tx", 32'(tx_count), 32'd10);
        check("burst_sb_empty", 32'(exp_q.size()), 32'd0);

        // Flush while a word is active
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_data = WIDTH'(12'h111 * i);
            step();
        end
        in_valid = 1'b0;
        wait_cs_low(20, "flush_accept");
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        check("flush_count", 32'(fifo_count), 32'd0);
        wait_idle(100, "flush_done");
        check("flush_tx", 32'(tx_count), 32'd11);
        saw = 1'b0;
        repeat (40) begin
            saw = saw | newd;
            step();
        end
        check("flush_no_newd", 32'(saw), 32'd0);

        // Timeout with an unresponsive master
        master_en = 1'b0;
        in_valid = 1'b1; in_data = 12'h7E7;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!newd && n < 10) begin
            step();
            n++;
        end
        check("tmo_launch", 32'(newd), 32'd1);
        n = 0;
        while (newd && n < 300) begin
            step();
            n++;
        end
        check("tmo_len", 32'(n), 32'(TIMEOUT));
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_count", 32'(fifo_count), 32'd0);
        check("tmo_tx", 32'(tx_count), 32'd11);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_clr", 32'(timeout_err), 32'd0);
        wait_idle(50, "tmo_done");

        // Asynchronous reset during ACTIVE
        master_en = 1'b1;
        in_valid = 1'b1; in_data = 12'h3C3;
        step();
        in_valid = 1'b0;
        wait_cs_low(20, "rst_accept");
        repeat (4) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("arst_newd",  32'(newd), 32'd0);
        check("arst_busy",  32'(busy), 32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_tx",    32'(tx_count), 32'd0);
        check("arst_din",   32'(din), 32'd0);
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        while (!cs_in && n < 30) begin
            step();
            n++;
        end
        saw = 1'b0;
        repeat (30) begin
            saw = saw | newd | busy;
            step();
        end
        check("post_rst_quiet", 32'(saw), 32'd0);
        check("post_rst_tx", 32'(tx_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
